// File: rtl/key_conditioner.sv
// key_conditioner: synchronise and debounce raw push-buttons into clean levels
// plus single-cycle press, release and long-press pulses per key.
module key_conditioner #(
   parameter int NKEYS             = 2,
   parameter int DEBOUNCE_CYCLES   = 50000,
   parameter int LONG_PRESS_CYCLES = 50000000
) (
   input  logic             CLOCK_50,
   input  logic             reset_n,
   input  logic [NKEYS-1:0] key_n,
   output logic [NKEYS-1:0] key_level,
   output logic [NKEYS-1:0] key_press,
   output logic [NKEYS-1:0] key_release,
   output logic [NKEYS-1:0] key_long
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(LONG_PRESS_CYCLES);
   // The detecting cycle in IDLE/PRESSED is the first stable sample, so the
   // wait states need DEBOUNCE_CYCLES-1 more.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES - 1);
   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] PRESSED      = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;

   for (genvar k = 0; k < NKEYS; k++) begin : g_key
      logic          s1_q, s2_q, p, held;
      logic [1:0]    state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [HW-1:0] hold_q, hold_d;
      logic          level_q, level_d, press_q, press_d;
      logic          release_q, release_d, long_q, long_d;

      assign p    = ~s2_q;
      assign held = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         level_d   = level_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         hold_d    = (held && hold_q != HOLD_MAX) ? hold_q + 1'b1 : hold_q;
         long_d    = held && (hold_q == HOLD_MAX - 1'b1);
         case (state_q)
            IDLE: begin
               if (p) begin
                  state_d = PRESS_WAIT;
                  cnt_d   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!p) begin
                  state_d = IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = PRESSED;
                  press_d = 1'b1;
                  level_d = 1'b1;
                  hold_d  = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            PRESSED: begin
               if (!p) begin
                  state_d = RELEASE_WAIT;
                  cnt_d   = '0;
               end
            end
            default: begin
               if (p) begin
                  state_d = PRESSED;
               end else if (cnt_q == CNT_LAST) begin
                  state_d   = IDLE;
                  level_d   = 1'b0;
                  release_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         endcase
      end

      always_ff @(posedge CLOCK_50) begin
         if (!reset_n) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            s1_q      <= key_n[k];
            s2_q      <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
         end
      end

      assign key_level[k]   = level_q;
      assign key_press[k]   = press_q;
      assign key_release[k] = release_q;
      assign key_long[k]    = long_q;
   end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench; expected pulse events are queued as
// stimulus is driven and matched against pulses observed on the outputs.
module tb_key_conditioner;
   typedef struct {
      int         cyc;
      logic [5:0] v;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] key_n = 2'b11;
   logic [1:0] key_level, key_press, key_release, key_long;
   int         cyc = 0;
   int         vectors = 0;
   int         errors = 0;
   ev_t        exp_q[$];
   ev_t        obs_q[$];

   key_conditioner #(
      .NKEYS(2),
      .DEBOUNCE_CYCLES(4),
      .LONG_PRESS_CYCLES(16)
   ) dut (
      .CLOCK_50(clk),
      .reset_n(reset_n),
      .key_n(key_n),
      .key_level(key_level),
      .key_press(key_press),
      .key_release(key_release),
      .key_long(key_long)
   );

   always #10 clk = ~clk;

   // v packs {long, release, press}, two bits each
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         cyc++;
         #1;
         if ({key_long, key_release, key_press} != 6'b0)
            obs_q.push_back('{cyc: cyc, v: {key_long, key_release, key_press}});
      end
   endtask

   task automatic expect_ev(input int c, input logic [5:0] v);
      exp_q.push_back('{cyc: c, v: v});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      key_n   = 2'b11;
      tick(2);
      reset_n = 1'b1;
      tick(2);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      key_n   = 2'b10;
      tick(3);
      vectors++;
      if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got %b, expected 00000000", {key_level, key_press, key_release, key_long});
      end
      key_n   = 2'b11;
      reset_n = 1'b1;
      tick(8);
      vectors++;
      if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
         errors++;
         $display("FAIL reset_idle: got %b, expected 00000000", {key_level, key_press, key_release, key_long});
      end
      vectors++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL reset_no_pulse: got %0d pulses, expected 0", obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_clean_press();
      ev_t e, o;
      do_reset();
      key_n = 2'b10;
      tick();
      expect_ev(cyc + 5, 6'b000001);
      tick(4);
      vectors++;
      if (key_level !== 2'b00) begin
         errors++;
         $display("FAIL clean_press_level_edge5: got %b, expected 00", key_level);
      end
      tick();
      vectors++;
      if (key_level !== 2'b01) begin
         errors++;
         $display("FAIL clean_press_level_edge6: got %b, expected 01", key_level);
      end
      tick(3);
      vectors++;
      if (key_level !== 2'b01) begin
         errors++;
         $display("FAIL clean_press_level_hold: got %b, expected 01", key_level);
      end
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '{cyc: -1, v: 6'b0};
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '{cyc: -1, v: 6'b0};
         vectors++;
         if (o.cyc != e.cyc || o.v !== e.v) begin
            errors++;
            $display("FAIL clean_press_event: got cyc=%0d v=%b, expected cyc=%0d v=%b", o.cyc, o.v, e.cyc, e.v);
         end
      end
   endtask

   task automatic test_bounce();
      ev_t e, o;
      do_reset();
      key_n = 2'b10;
      tick(3);
      key_n = 2'b11;
      tick();
      key_n = 2'b10;
      tick(3);
      key_n = 2'b11;
      tick(10);
      vectors++;
      if (key_level !== 2'b00) begin
         errors++;
         $display("FAIL bounce_level: got %b, expected 00", key_level);
      end
      // a full press afterwards must see the normal latency, proving IDLE
      key_n = 2'b10;
      tick();
      expect_ev(cyc + 5, 6'b000001);
      tick(7);
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '{cyc: -1, v: 6'b0};
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '{cyc: -1, v: 6'b0};
         vectors++;
         if (o.cyc != e.cyc || o.v !== e.v) begin
            errors++;
            $display("FAIL bounce_event: got cyc=%0d v=%b, expected cyc=%0d v=%b", o.cyc, o.v, e.cyc, e.v);
         end
      end
   endtask

   task automatic test_release_bounce();
      ev_t e, o;
      do_reset();
      key_n = 2'b10;
      tick();
      expect_ev(cyc + 5, 6'b000001);
      tick(7);
      key_n = 2'b11;
      tick(2);
      key_n = 2'b10;
      tick();
      key_n = 2'b11;
      tick();
      expect_ev(cyc + 5, 6'b000100);
      tick(4);
      vectors++;
      if (key_level !== 2'b01) begin
         errors++;
         $display("FAIL release_level_before: got %b, expected 01", key_level);
      end
      tick();
      vectors++;
      if (key_level !== 2'b00) begin
         errors++;
         $display("FAIL release_level_edge6: got %b, expected 00", key_level);
      end
      tick(20);
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '{cyc: -1, v: 6'b0};
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '{cyc: -1, v: 6'b0};
         vectors++;
         if (o.cyc != e.cyc || o.v !== e.v) begin
            errors++;
            $display("FAIL release_event: got cyc=%0d v=%b, expected cyc=%0d v=%b", o.cyc, o.v, e.cyc, e.v);
         end
      end
   endtask

   task automatic test_long_press();
      ev_t e, o;
      int  p;
      do_reset();
      key_n = 2'b10;
      tick();
      p = cyc + 5;
      expect_ev(p, 6'b000001);
      expect_ev(p + 15, 6'b010000);
      tick(5 + 40);
      vectors++;
      if (key_level !== 2'b01) begin
         errors++;
         $display("FAIL long_level_held: got %b, expected 01", key_level);
      end
      key_n = 2'b11;
      tick();
      expect_ev(cyc + 5, 6'b000100);
      tick(10);
      vectors++;
      if (key_level !== 2'b00) begin
         errors++;
         $display("FAIL long_level_after: got %b, expected 00", key_level);
      end
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '{cyc: -1, v: 6'b0};
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '{cyc: -1, v: 6'b0};
         vectors++;
         if (o.cyc != e.cyc || o.v !== e.v) begin
            errors++;
            $display("FAIL long_event: got cyc=%0d v=%b, expected cyc=%0d v=%b", o.cyc, o.v, e.cyc, e.v);
         end
      end
   endtask

   task automatic test_reset_mid();
      ev_t e, o;
      do_reset();
      key_n = 2'b10;
      tick(4);
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b, expected 00000000", {key_level, key_press, key_release, key_long});
         end
      end
      reset_n = 1'b1;
      tick();
      expect_ev(cyc + 5, 6'b000001);
      tick(4);
      vectors++;
      if (key_level !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid_level_edge5: got %b, expected 00", key_level);
      end
      tick();
      vectors++;
      if (key_level !== 2'b01) begin
         errors++;
         $display("FAIL reset_mid_level_edge6: got %b, expected 01", key_level);
      end
      tick(3);
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '{cyc: -1, v: 6'b0};
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '{cyc: -1, v: 6'b0};
         vectors++;
         if (o.cyc != e.cyc || o.v !== e.v) begin
            errors++;
            $display("FAIL reset_mid_event: got cyc=%0d v=%b, expected cyc=%0d v=%b", o.cyc, o.v, e.cyc, e.v);
         end
      end
   endtask

   task automatic test_both_keys();
      ev_t e, o;
      do_reset();
      key_n = 2'b00;
      tick();
      expect_ev(cyc + 5, 6'b000011);
      tick(7);
      vectors++;
      if (key_level !== 2'b11) begin
         errors++;
         $display("FAIL both_level: got %b, expected 11", key_level);
      end
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '{cyc: -1, v: 6'b0};
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '{cyc: -1, v: 6'b0};
         vectors++;
         if (o.cyc != e.cyc || o.v !== e.v) begin
            errors++;
            $display("FAIL both_event: got cyc=%0d v=%b, expected cyc=%0d v=%b", o.cyc, o.v, e.cyc, e.v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_bounce();
      test_long_press();
      test_reset_mid();
      test_both_keys();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
